cpu_sequencer: RTL and testbench

//  Multi-cycle sequencer that wraps the combinational instruction decoder and

---
 rtl/cpu_sequencer.sv | 150 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM sequencer around the combinational decoder.
// It shares one memory port between fetch and load/store, flags errors and counts retired instructions.
module cpu_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op_class,
  input  logic             ctl_regwrite,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_en,
  output logic             rf_we,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       err_code,
  output logic             halted
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WAIT_W-1:0] wait_r;
  logic              timeout_s;
  logic              retire_s;
  logic              err_set_s;
  logic [1:0]        err_val_s;

  // wait_r holds the count of earlier not-ready request cycles.
  // Reaching TIMEOUT-1 means the current cycle is the last one allowed.
  assign timeout_s = (wait_r == WAIT_W'(TIMEOUT - 1));

  // Next-state and strobe decode; reset forces every output low
  always_comb begin
    state_nxt_s = state_r;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_load     = 1'b0;
    pc_en       = 1'b0;
    rf_we       = 1'b0;
    halted      = 1'b0;
    retire_s    = 1'b0;
    err_set_s   = 1'b0;
    err_val_s   = 2'b00;
    if (rst) begin
      state_nxt_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load     = 1'b1;
            state_nxt_s = ST_EXEC;
          end else if (timeout_s) begin
            err_set_s   = 1'b1;
            err_val_s   = 2'b01;
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end
        ST_EXEC: begin
          case (op_class)
            3'b011, 3'b101: begin
              err_set_s   = 1'b1;
              err_val_s   = 2'b10;
              state_nxt_s = ST_HALT;
            end
            3'b001, 3'b010: begin
              state_nxt_s = ST_MEM;
            end
            default: begin
              pc_en       = 1'b1;
              rf_we       = ctl_regwrite;
              retire_s    = 1'b1;
              state_nxt_s = ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (op_class == 3'b010);
          if (mem_ready) begin
            pc_en       = 1'b1;
            rf_we       = (op_class == 3'b001);
            retire_s    = 1'b1;
            state_nxt_s = ST_FETCH;
          end else if (timeout_s) begin
            err_set_s   = 1'b1;
            err_val_s   = 2'b01;
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_MEM;
          end
        end
        ST_HALT: begin
          halted      = 1'b1;
          state_nxt_s = ST_HALT;
        end
        default: begin
          state_nxt_s = ST_FETCH;
        end
      endcase
    end
  end

  // State, wait counter, retired counter and sticky error register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_FETCH;
      wait_r   <= {WAIT_W{1'b0}};
      retired  <= {CNT_W{1'b0}};
      err_code <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      // Any state change starts a fresh wait window for FETCH or MEM
      if (state_nxt_s != state_r) begin
        wait_r <= {WAIT_W{1'b0}};
      end else if (mem_req && !mem_ready) begin
        wait_r <= wait_r + WAIT_W'(1);
      end else begin
        wait_r <= wait_r;
      end
      if (retire_s) begin
        retired <= retired + CNT_W'(1);
      end else begin
        retired <= retired;
      end
      if (err_set_s) begin
        err_code <= err_val_s;
      end else begin
        err_code <= err_code;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer.
// A second instance with CNT_W=4 covers the wrap of the retired counter.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  op_class = 3'b000;
  logic        ctl_regwrite = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, addr_sel, ir_load, pc_en, rf_we, halted;
  logic [15:0] retired;
  logic [1:0]  err_code;

  logic        mem_req4, mem_we4, addr_sel4, ir_load4, pc_en4, rf_we4, halted4;
  logic [3:0]  retired4;
  logic [1:0]  err_code4;

  logic [6:0]  outs;
  assign outs = {mem_req, mem_we, addr_sel, ir_load, pc_en, rf_we, halted};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .op_class(op_class), .ctl_regwrite(ctl_regwrite),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_load(ir_load), .pc_en(pc_en), .rf_we(rf_we), .retired(retired),
    .err_code(err_code), .halted(halted)
  );

  cpu_sequencer #(.TIMEOUT(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .op_class(op_class), .ctl_regwrite(ctl_regwrite),
    .mem_ready(mem_ready), .mem_req(mem_req4), .mem_we(mem_we4), .addr_sel(addr_sel4),
    .ir_load(ir_load4), .pc_en(pc_en4), .rf_we(rf_we4), .retired(retired4),
    .err_code(err_code4), .halted(halted4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // outs order: mem_req mem_we addr_sel ir_load pc_en rf_we halted
  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; op_class = 3'b010;
    #1;
    n_cmp++; if (outs !== 7'b0000000) begin n_err++; $display("FAIL reset_outs: got %b expected %b", outs, 7'b0000000); end
    step();
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    n_cmp++; if (retired !== 16'd0) begin n_err++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    n_cmp++; if (err_code !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b expected 00", err_code); end
    n_cmp++; if (outs !== 7'b1000000) begin n_err++; $display("FAIL reset_fetch: got %b expected %b", outs, 7'b1000000); end
  endtask

  task automatic test_alu();
    do_reset();
    op_class = 3'b000; ctl_regwrite = 1'b1; mem_ready = 1'b1;
    #1;
    n_cmp++; if (outs !== 7'b1001000) begin n_err++; $display("FAIL alu_fetch: got %b expected %b", outs, 7'b1001000); end
    step();
    n_cmp++; if (outs !== 7'b0000110) begin n_err++; $display("FAIL alu_exec: got %b expected %b", outs, 7'b0000110); end
    step();
    n_cmp++; if (retired !== 16'd1) begin n_err++; $display("FAIL alu_retired: got %0d expected 1", retired); end
    n_cmp++; if (outs !== 7'b1001000) begin n_err++; $display("FAIL alu_refetch: got %b expected %b", outs, 7'b1001000); end
  endtask

  task automatic test_load_store();
    do_reset();
    op_class = 3'b001; ctl_regwrite = 1'b1; mem_ready = 1'b1;
    #1;
    n_cmp++; if (outs !== 7'b1001000) begin n_err++; $display("FAIL ld_fetch: got %b expected %b", outs, 7'b1001000); end
    step();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (outs !== 7'b0000000) begin n_err++; $display("FAIL ld_exec: got %b expected %b", outs, 7'b0000000); end
    step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (outs !== 7'b1010000) begin n_err++; $display("FAIL ld_wait%0d: got %b expected %b", i, outs, 7'b1010000); end
      step();
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (outs !== 7'b1010110) begin n_err++; $display("FAIL ld_ready: got %b expected %b", outs, 7'b1010110); end
    step();
    n_cmp++; if (retired !== 16'd1) begin n_err++; $display("FAIL ld_retired: got %0d expected 1", retired); end
    // Store follows back to back
    op_class = 3'b010;
    #1;
    n_cmp++; if (outs !== 7'b1001000) begin n_err++; $display("FAIL st_fetch: got %b expected %b", outs, 7'b1001000); end
    step();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (outs !== 7'b0000000) begin n_err++; $display("FAIL st_exec: got %b expected %b", outs, 7'b0000000); end
    step();
    n_cmp++; if (outs !== 7'b1110000) begin n_err++; $display("FAIL st_wait: got %b expected %b", outs, 7'b1110000); end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (outs !== 7'b1110100) begin n_err++; $display("FAIL st_ready: got %b expected %b", outs, 7'b1110100); end
    step();
    n_cmp++; if (outs !== 7'b1001000) begin n_err++; $display("FAIL st_after: got %b expected %b", outs, 7'b1001000); end
    n_cmp++; if (retired !== 16'd2) begin n_err++; $display("FAIL st_retired: got %0d expected 2", retired); end
  endtask

  task automatic test_timeout();
    do_reset();
    op_class = 3'b000; ctl_regwrite = 1'b0; mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (outs !== 7'b1000000) begin n_err++; $display("FAIL to_wait%0d: got %b expected %b", i, outs, 7'b1000000); end
      step();
    end
    n_cmp++; if (outs !== 7'b0000001) begin n_err++; $display("FAIL to_halt: got %b expected %b", outs, 7'b0000001); end
    n_cmp++; if (err_code !== 2'b01) begin n_err++; $display("FAIL to_err: got %b expected 01", err_code); end
    mem_ready = 1'b1;
    step();
    n_cmp++; if (outs !== 7'b0000001) begin n_err++; $display("FAIL to_hold: got %b expected %b", outs, 7'b0000001); end
    n_cmp++; if (retired !== 16'd0) begin n_err++; $display("FAIL to_retired: got %0d expected 0", retired); end
    // Ready on the 16th request cycle completes normally
    do_reset();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      step();
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (outs !== 7'b1001000) begin n_err++; $display("FAIL to_edge_fetch: got %b expected %b", outs, 7'b1001000); end
    step();
    n_cmp++; if (outs !== 7'b0000100) begin n_err++; $display("FAIL to_edge_exec: got %b expected %b", outs, 7'b0000100); end
    n_cmp++; if (err_code !== 2'b00) begin n_err++; $display("FAIL to_edge_err: got %b expected 00", err_code); end
  endtask

  task automatic test_illegal();
    do_reset();
    op_class = 3'b000; ctl_regwrite = 1'b1; mem_ready = 1'b1;
    step();
    step();
    op_class = 3'b101;
    #1;
    n_cmp++; if (outs !== 7'b1001000) begin n_err++; $display("FAIL ill_fetch: got %b expected %b", outs, 7'b1001000); end
    step();
    n_cmp++; if (outs !== 7'b0000000) begin n_err++; $display("FAIL ill_exec: got %b expected %b", outs, 7'b0000000); end
    step();
    n_cmp++; if (outs !== 7'b0000001) begin n_err++; $display("FAIL ill_halt: got %b expected %b", outs, 7'b0000001); end
    n_cmp++; if (err_code !== 2'b10) begin n_err++; $display("FAIL ill_err: got %b expected 10", err_code); end
    n_cmp++; if (retired !== 16'd1) begin n_err++; $display("FAIL ill_retired: got %0d expected 1", retired); end
    rst = 1'b1;
    #1;
    n_cmp++; if (outs !== 7'b0000000) begin n_err++; $display("FAIL ill_rst_outs: got %b expected %b", outs, 7'b0000000); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (outs !== 7'b1001000) begin n_err++; $display("FAIL ill_rst_fetch: got %b expected %b", outs, 7'b1001000); end
    n_cmp++; if (err_code !== 2'b00) begin n_err++; $display("FAIL ill_rst_err: got %b expected 00", err_code); end
    op_class = 3'b011;
    step();
    step();
    n_cmp++; if (err_code !== 2'b10) begin n_err++; $display("FAIL ill011_err: got %b expected 10", err_code); end
  endtask

  task automatic test_wrap_and_midreset();
    do_reset();
    op_class = 3'b000; ctl_regwrite = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      step();
    end
    n_cmp++; if (retired4 !== 4'd15) begin n_err++; $display("FAIL wrap_15: got %0d expected 15", retired4); end
    step();
    step();
    n_cmp++; if (retired4 !== 4'd0) begin n_err++; $display("FAIL wrap_0: got %0d expected 0", retired4); end
    n_cmp++; if (retired !== 16'd16) begin n_err++; $display("FAIL wrap_wide: got %0d expected 16", retired); end
    op_class = 3'b010;
    step();
    mem_ready = 1'b0;
    step();
    n_cmp++; if (outs !== 7'b1110000) begin n_err++; $display("FAIL mid_mem: got %b expected %b", outs, 7'b1110000); end
    rst = 1'b1;
    #1;
    n_cmp++; if (outs !== 7'b0000000) begin n_err++; $display("FAIL mid_rst_outs: got %b expected %b", outs, 7'b0000000); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (outs !== 7'b1000000) begin n_err++; $display("FAIL mid_fetch: got %b expected %b", outs, 7'b1000000); end
    n_cmp++; if (retired !== 16'd0) begin n_err++; $display("FAIL mid_retired: got %0d expected 0", retired); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_timeout();
    test_illegal();
    test_wrap_and_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
